// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder back end: frame sequencer state
// encoding and default frame geometry.
package viterbi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACS   = 3'd1,
    SEL   = 3'd2,
    TRACE = 3'd3,
    OUT   = 3'd4
  } tb_ctrl_state_t;

  localparam int TB_DEPTH_DEFAULT = 64;
  localparam int TB_WORD_W        = TB_DEPTH_DEFAULT * 2;

endpackage

// File: rtl/viterbi_tb_ctrl_if.sv
// Handshake and strobe bundle between the frame sequencer (master) and the
// surrounding intake / ACS / traceback / consumer logic (slave).
interface viterbi_tb_ctrl_if
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = TB_DEPTH_DEFAULT
) ();

  logic                    i_start;
  logic                    i_rx_valid;
  logic                    o_rx_ready;
  logic                    o_en_acs;
  logic                    o_en_sel;
  logic                    o_tb_rst_n;
  logic                    o_en_t;
  logic                    i_decoder_done;
  logic [TB_DEPTH*2-1:0]   i_decoder_data;
  logic [TB_DEPTH*2-1:0]   o_data;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_busy;
  logic                    o_err;

  modport master (
    input  i_start, i_rx_valid, i_decoder_done, i_decoder_data, i_ready,
    output o_rx_ready, o_en_acs, o_en_sel, o_tb_rst_n, o_en_t,
           o_data, o_valid, o_busy, o_err
  );

  modport slave (
    output i_start, i_rx_valid, i_decoder_done, i_decoder_data, i_ready,
    input  o_rx_ready, o_en_acs, o_en_sel, o_tb_rst_n, o_en_t,
           o_data, o_valid, o_busy, o_err
  );

endinterface

// File: rtl/viterbi_tb_ctrl.sv
// Viterbi back-end frame sequencer: symbol intake into ACS, best-node select,
// traceback with timeout, and a held output word released on handshake.
module viterbi_tb_ctrl
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH   = TB_DEPTH_DEFAULT,
  parameter int TB_TIMEOUT = TB_DEPTH + 4
) (
  input logic              clk,
  input logic              rst,
  viterbi_tb_ctrl_if.master bus
);

  localparam int SYM_W = $clog2(TB_DEPTH + 1);
  localparam int TO_W  = $clog2(TB_TIMEOUT + 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(TB_DEPTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TB_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_ACS   = 3'(ACS);
  localparam logic [2:0] S_SEL   = 3'(SEL);
  localparam logic [2:0] S_TRACE = 3'(TRACE);
  localparam logic [2:0] S_OUT   = 3'(OUT);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [SYM_W-1:0] sym_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             rx_ready;
  logic             en_acs;
  logic             accept;
  logic             start_ok;
  logic             last_sym;
  logic             done_hit;
  logic             timeout;

  assign rx_ready = (state == S_ACS);
  assign en_acs   = bus.i_rx_valid & rx_ready;
  assign accept   = (state == S_OUT) & bus.i_ready;
  // A start request only counts in IDLE or on the OUT accept cycle; it is never queued.
  assign start_ok = bus.i_start & ((state == S_IDLE) | accept);
  assign last_sym = en_acs & (sym_cnt == SYM_LAST);
  assign done_hit = (state == S_TRACE) & bus.i_decoder_done;
  assign timeout  = (state == S_TRACE) & ~bus.i_decoder_done & (to_cnt == TO_LAST);

  assign bus.o_rx_ready = rx_ready;
  assign bus.o_en_acs   = en_acs;
  assign bus.o_en_sel   = (state == S_SEL);
  assign bus.o_en_t     = (state == S_TRACE);
  assign bus.o_busy     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.i_start) state_nxt = S_ACS;
      S_ACS:   if (last_sym) state_nxt = S_SEL;
      S_SEL:   state_nxt = S_TRACE;
      S_TRACE: begin
        if (done_hit)     state_nxt = S_OUT;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_OUT:   if (accept) state_nxt = bus.i_start ? S_ACS : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      sym_cnt        <= '0;
      to_cnt         <= '0;
      bus.o_data     <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_err      <= 1'b0;
      bus.o_tb_rst_n <= 1'b0;
    end else begin
      state <= state_nxt;
      // Traceback clear is low during SEL and for the cycle after a timeout abort.
      bus.o_tb_rst_n <= ~((state_nxt == S_SEL) | timeout);

      if (start_ok)    sym_cnt <= '0;
      else if (en_acs) sym_cnt <= sym_cnt + 1'b1;

      if (state == S_SEL)        to_cnt <= '0;
      else if (state == S_TRACE) to_cnt <= to_cnt + 1'b1;

      if (done_hit) begin
        bus.o_data  <= bus.i_decoder_data;
        bus.o_valid <= 1'b1;
      end else if (accept) begin
        bus.o_valid <= 1'b0;
      end

      if (timeout)       bus.o_err <= 1'b1;
      else if (start_ok) bus.o_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Directed bench for viterbi_tb_ctrl (TB_DEPTH=8, TB_TIMEOUT=12) with a
// queue-based scoreboard on the output handshake and a small traceback model.
module tb_viterbi_tb_ctrl;

  logic clk = 1'b0;
  logic rst;

  viterbi_tb_ctrl_if #(.TB_DEPTH(8)) bus ();

  viterbi_tb_ctrl #(.TB_DEPTH(8), .TB_TIMEOUT(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          acs_pulses = 0;
  int          tb_cnt = 0;
  bit          model_en = 1'b0;
  logic [15:0] exp_q[$];

  // Traceback unit stand-in: raises done once 8 enabled steps have elapsed since its clear.
  always @(posedge clk) begin
    if (!bus.o_tb_rst_n) begin
      tb_cnt             <= 0;
      bus.i_decoder_done <= 1'b0;
    end else if (bus.o_en_t) begin
      tb_cnt <= tb_cnt + 1;
      if (model_en && tb_cnt == 7) bus.i_decoder_done <= 1'b1;
    end
  end

  always @(negedge clk) if (bus.o_en_acs) acs_pulses++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output word is compared against the oldest expectation.
  always @(negedge clk) begin
    if (bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected none", bus.o_data);
      end else begin
        chk("out_data", {16'h0, bus.o_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    chk("start_busy", bus.o_busy, 1);
    chk("start_rx_ready", bus.o_rx_ready, 1);
    chk("start_err_clr", bus.o_err, 0);
  endtask

  task automatic feed(input bit toggle, input int poke, input int exp_cycles);
    int n = 0;
    acs_pulses = 0;
    while (bus.o_rx_ready && n < 40) begin
      bus.i_rx_valid = toggle ? ((n % 2) == 0) : 1'b1;
      bus.i_start    = (n == poke);
      step();
      n++;
    end
    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b1;
    chk("acs_pulses", acs_pulses, 8);
    chk("acs_cycles", n, exp_cycles);
    chk("sel_en", bus.o_en_sel, 1);
    chk("sel_tb_rst_n", bus.o_tb_rst_n, 0);
    chk("sel_en_t", bus.o_en_t, 0);
    chk("sel_no_acs", bus.o_en_acs, 0);
    bus.i_rx_valid = 1'b0;
    step();
    chk("trace_en_t", bus.o_en_t, 1);
    chk("trace_tb_rst_n", bus.o_tb_rst_n, 1);
    chk("trace_en_sel", bus.o_en_sel, 0);
  endtask

  task automatic trace(input bit done_exp);
    int n = 0;
    if (done_exp) begin
      while (!bus.o_valid && n < 30) begin step(); n++; end
      chk("trace_steps", n, 9);
      chk("out_en_t", bus.o_en_t, 0);
      chk("out_busy", bus.o_busy, 1);
      chk("out_rx_ready", bus.o_rx_ready, 0);
    end else begin
      while (bus.o_busy && n < 30) begin step(); n++; end
      chk("timeout_steps", n, 12);
      chk("timeout_err", bus.o_err, 1);
      chk("timeout_tb_rst_n", bus.o_tb_rst_n, 0);
      chk("timeout_valid", bus.o_valid, 0);
      chk("timeout_en_t", bus.o_en_t, 0);
      step();
      chk("post_to_tb_rst_n", bus.o_tb_rst_n, 1);
      chk("post_to_err_sticky", bus.o_err, 1);
      chk("post_to_idle", bus.o_busy, 0);
    end
  endtask

  task automatic release_idle();
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    chk("rel_valid", bus.o_valid, 0);
    chk("rel_idle", bus.o_busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_decoder_data = '0;
    repeat (3) step();
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_tb_rst_n", bus.o_tb_rst_n, 0);
    chk("rst_data", {16'h0, bus.o_data}, 0);
    chk("rst_en_t", bus.o_en_t, 0);
    chk("rst_rx_ready", bus.o_rx_ready, 0);
    rst = 1'b0;
    step();
    chk("idle_tb_rst_n", bus.o_tb_rst_n, 1);

    // Frame with continuous symbols and a stalled consumer.
    model_en = 1'b1;
    bus.i_decoder_data = 16'hA5C3;
    exp_q.push_back(16'hA5C3);
    start_frame();
    feed(1'b0, -1, 8);
    trace(1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", bus.o_valid, 1);
      chk("hold_data", {16'h0, bus.o_data}, 32'hA5C3);
      step();
    end
    release_idle();

    // Alternating symbol valid: 8 accepts spread over 15 ACS cycles.
    bus.i_decoder_data = 16'h3C5A;
    exp_q.push_back(16'h3C5A);
    start_frame();
    feed(1'b1, -1, 15);
    trace(1'b1);
    release_idle();

    // Traceback never finishes.
    model_en = 1'b0;
    start_frame();
    feed(1'b0, -1, 8);
    trace(1'b0);

    // Back-to-back frames: restart on the accept cycle.
    model_en = 1'b1;
    bus.i_decoder_data = 16'h1234;
    exp_q.push_back(16'h1234);
    start_frame();
    feed(1'b0, -1, 8);
    trace(1'b1);
    bus.i_decoder_data = 16'h0F0F;
    exp_q.push_back(16'h0F0F);
    bus.i_ready = 1'b1;
    bus.i_start = 1'b1;
    step();
    bus.i_ready = 1'b0;
    bus.i_start = 1'b0;
    chk("b2b_busy", bus.o_busy, 1);
    chk("b2b_rx_ready", bus.o_rx_ready, 1);
    chk("b2b_valid", bus.o_valid, 0);
    feed(1'b0, -1, 8);
    trace(1'b1);
    chk("b2b_data", {16'h0, bus.o_data}, 32'h0F0F);
    release_idle();

    // Start during ACS is ignored; reset mid-traceback abandons the frame.
    start_frame();
    feed(1'b0, 3, 8);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_en_t", bus.o_en_t, 0);
    chk("midrst_valid", bus.o_valid, 0);
    chk("midrst_tb_rst_n", bus.o_tb_rst_n, 0);
    repeat (12) step();
    chk("midrst_no_valid", bus.o_valid, 0);
    chk("midrst_idle", bus.o_busy, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
